// File: rtl/double_to_long_pkg.sv
// ----------------------------------------------------------------------------
// double_to_long_pkg
// Shared types and constants for the binary64 -> signed 64-bit converter.
//   state_t        : converter FSM states
//   EXP_BIAS       : binary64 exponent bias
//   EXP_SPECIAL    : exponent field value for Inf/NaN
//   MANT_W         : stored mantissa width
//   INT_INDEFINITE : result returned for out-of-range and Inf/NaN operands
// ----------------------------------------------------------------------------
package double_to_long_pkg;

   typedef enum logic [2:0] {
      GET_A,
      UNPACK,
      CONVERT,
      SIGN,
      PUT_Z
   } state_t;

   localparam logic signed [11:0] EXP_BIAS       = 12'sd1023;
   localparam logic [10:0]        EXP_SPECIAL    = 11'h7FF;
   localparam int                 MANT_W         = 52;
   localparam logic [63:0]        INT_INDEFINITE = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/d2l_shifter.sv
// ----------------------------------------------------------------------------
// d2l_shifter
// Combinational alignment of the significand {1,M} to an integer magnitude
// for an unbiased exponent e (truncation toward zero).
//   mant_full [52:0] : significand with hidden bit
//   exp_unb   [11:0] : unbiased exponent, signed
//   magnitude [63:0] : integer part of the value
//   sticky           : discarded fraction bits were nonzero
// Callers handle e >= 63 and Inf/NaN before using the result; for those the
// left shift simply wraps and the magnitude is meaningless.
// ----------------------------------------------------------------------------
module d2l_shifter
   import double_to_long_pkg::*;
(
   input  logic [MANT_W:0]    mant_full,
   input  logic signed [11:0] exp_unb,
   output logic [63:0]        magnitude,
   output logic               sticky
);

   logic [63:0] ext;
   logic [63:0] mask;
   logic [5:0]  lsh;
   logic [5:0]  rsh;

   always_comb begin
      ext       = {{(63 - MANT_W){1'b0}}, mant_full};
      // Only the low six bits matter: e is in 52..62 for left shifts and
      // 0..51 for right shifts, so modulo-64 arithmetic is exact there.
      lsh       = exp_unb[5:0] - 6'(MANT_W);
      rsh       = 6'(MANT_W) - exp_unb[5:0];
      mask      = (64'd1 << rsh) - 64'd1;
      magnitude = '0;
      sticky    = 1'b0;
      if (exp_unb < 12'sd0) begin
         magnitude = '0;
         sticky    = |mant_full;
      end else if (exp_unb >= 12'sd52) begin
         magnitude = ext << lsh;
      end else begin
         magnitude = ext >> rsh;
         sticky    = |(ext & mask);
      end
   end

endmodule

// File: rtl/double_to_long.sv
// ----------------------------------------------------------------------------
// double_to_long
// Converts an IEEE-754 binary64 operand to a signed 64-bit integer, rounding
// toward zero. Single-issue FSM: GET_A -> UNPACK -> CONVERT -> SIGN -> PUT_Z.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   input_a[63:0]     : binary64 operand, captured when stb && ack
//   input_a_stb/ack   : input handshake (ack registered)
//   output_z[63:0]    : signed integer result (registered)
//   output_z_stb/ack  : output handshake (stb registered)
// Optional (macro DOUBLE_TO_LONG_FLAGS_EN):
//   output_z_invalid  : result forced to INT_INDEFINITE
//   output_z_inexact  : nonzero fraction bits were discarded
// ----------------------------------------------------------------------------
module double_to_long
   import double_to_long_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [63:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
`ifdef DOUBLE_TO_LONG_FLAGS_EN
   ,
   output logic        output_z_invalid,
   output logic        output_z_inexact
`endif
);

   state_t state, state_next;
   logic   ack_next;
   logic   stb_next;

   logic [63:0]        a_reg;
   logic               sgn;
   logic [10:0]        exp_raw;
   logic [MANT_W-1:0]  mant;
   logic signed [11:0] exp_unb;
   logic signed [63:0] mag;
   logic               forced;
   logic               forced_c;
   logic [63:0]        sh_mag;
   logic               sh_sticky;
`ifdef DOUBLE_TO_LONG_FLAGS_EN
   logic               inexact;
`endif

   // Control: next state and handshake outputs
   always_comb begin
      state_next = state;
      ack_next   = input_a_ack;
      stb_next   = output_z_stb;
      case (state)
         GET_A: begin
            ack_next = 1'b1;
            if (input_a_stb && input_a_ack) begin
               ack_next   = 1'b0;
               state_next = UNPACK;
            end
         end
         UNPACK:  state_next = CONVERT;
         CONVERT: state_next = SIGN;
         SIGN: begin
            stb_next   = 1'b1;
            state_next = PUT_Z;
         end
         PUT_Z: begin
            if (output_z_stb && output_z_ack) begin
               stb_next   = 1'b0;
               state_next = GET_A;
            end
         end
         default: state_next = GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= GET_A;
         input_a_ack  <= 1'b0;
         output_z_stb <= 1'b0;
      end else begin
         state        <= state_next;
         input_a_ack  <= ack_next;
         output_z_stb <= stb_next;
      end
   end

   d2l_shifter u_shifter (
      .mant_full (({1'b1, mant})),
      .exp_unb   (exp_unb),
      .magnitude (sh_mag),
      .sticky    (sh_sticky)
   );

   // -2^63 is representable and must not be flagged as forced, even though
   // its bit pattern equals INT_INDEFINITE.
   always_comb begin
      forced_c = (exp_raw == EXP_SPECIAL) ||
                 ((exp_unb >= 12'sd63) &&
                  !(sgn && (exp_unb == 12'sd63) && (mant == '0)));
   end

   // Datapath working registers (no reset needed; always written before use)
   always_ff @(posedge clk) begin
      case (state)
         GET_A: begin
            if (input_a_stb && input_a_ack) a_reg <= input_a;
         end
         // UNPACK stage
         UNPACK: begin
            sgn     <= a_reg[63];
            exp_raw <= a_reg[62:52];
            mant    <= a_reg[MANT_W-1:0];
            exp_unb <= signed'({1'b0, a_reg[62:52]}) - EXP_BIAS;
         end
         // CONVERT stage
         CONVERT: begin
            forced <= forced_c;
            if (forced_c) begin
               mag <= signed'(INT_INDEFINITE);
            end else if (exp_raw == 11'd0) begin
               mag <= '0;
            end else begin
               mag <= signed'(sh_mag);
            end
`ifdef DOUBLE_TO_LONG_FLAGS_EN
            if (forced_c)                inexact <= 1'b0;
            else if (exp_raw == 11'd0)   inexact <= |mant;
            else                         inexact <= sh_sticky;
`endif
         end
         default: ;
      endcase
   end

   // SIGN stage: registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         output_z <= '0;
`ifdef DOUBLE_TO_LONG_FLAGS_EN
         output_z_invalid <= 1'b0;
         output_z_inexact <= 1'b0;
`endif
      end else if (state == SIGN) begin
         output_z <= (sgn && !forced) ? 64'(-mag) : 64'(mag);
`ifdef DOUBLE_TO_LONG_FLAGS_EN
         output_z_invalid <= forced;
         output_z_inexact <= inexact;
`endif
      end
   end

`ifndef DOUBLE_TO_LONG_FLAGS_EN
   // Fraction-loss indication is only consumed by the optional flag outputs.
   logic unused_sticky;
   assign unused_sticky = sh_sticky;
`endif

endmodule

// File: tb/tb_double_to_long.sv
// ----------------------------------------------------------------------------
// tb_double_to_long
// Self-checking bench for double_to_long. A real-arithmetic reference model
// supplies expected results for random operands; directed vectors carry their
// expected values as constants. Flag checks are active when
// DOUBLE_TO_LONG_FLAGS_EN is defined.
// ----------------------------------------------------------------------------
module tb_double_to_long;

   localparam logic [63:0] IND = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [63:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;
`ifdef DOUBLE_TO_LONG_FLAGS_EN
   logic        output_z_invalid;
   logic        output_z_inexact;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   double_to_long dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
`ifdef DOUBLE_TO_LONG_FLAGS_EN
      ,
      .output_z_invalid (output_z_invalid),
      .output_z_inexact (output_z_inexact)
`endif
   );

   // Reference: C-style truncating cast computed with real arithmetic.
   function automatic void ref_conv(input logic [63:0] a, output logic [63:0] z,
                                    output logic inv, output logic inx);
      real r;
      real t;
      real lim;
      lim = 2.0 ** 63;
      z = IND; inv = 1'b1; inx = 1'b0;
      if (a[62:52] == 11'h7FF) return;
      r = $bitstoreal(a);
      if (r >= lim || r < -lim) return;
      t   = (r >= 0.0) ? $floor(r) : $ceil(r);
      z   = 64'(longint'(t));
      inv = 1'b0;
      inx = (t != r);
   endfunction

   // Drives one operand through the handshake; returns the observed result
   // and the number of edges from the accept edge until output_z_stb is seen.
   task automatic conv(input logic [63:0] a, input logic ack_idle,
                       output logic [63:0] z, output int lat,
                       output logic inv, output logic inx, output bit ok);
      ok = 1'b0; lat = 0; z = '0; inv = 1'b0; inx = 1'b0;
      @(negedge clk);
      input_a     = a;
      input_a_stb = 1'b1;
      for (int i = 0; i < 20 && !input_a_ack; i++) @(negedge clk);
      n_cmp++;
      if (!input_a_ack) begin
         n_err++;
         $display("FAIL accept_timeout: input_a_ack=%b required 1", input_a_ack);
         input_a_stb = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      input_a_stb = 1'b0;
      while (!output_z_stb && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (!output_z_stb) begin
         n_err++;
         $display("FAIL result_timeout: output_z_stb=%b required 1", output_z_stb);
         return;
      end
      z = output_z;
`ifdef DOUBLE_TO_LONG_FLAGS_EN
      inv = output_z_invalid;
      inx = output_z_inexact;
`endif
      ok = 1'b1;
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = ack_idle;
   endtask

   task automatic test_reset();
      rst = 1'b1; input_a = '0; input_a_stb = 1'b0; output_z_ack = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({input_a_ack, output_z_stb, output_z} !== {1'b0, 1'b0, 64'h0}) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b stb=%b z=%h required 0 0 0",
                  input_a_ack, output_z_stb, output_z);
      end
`ifdef DOUBLE_TO_LONG_FLAGS_EN
      n_cmp++;
      if ({output_z_invalid, output_z_inexact} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_flags: inv=%b inx=%b required 0 0",
                  output_z_invalid, output_z_inexact);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (input_a_ack !== 1'b1) begin
         n_err++;
         $display("FAIL ack_after_reset: ack=%b required 1", input_a_ack);
      end
   endtask

   task automatic test_directed();
      logic [63:0] vin [11] = '{64'h3FF0_0000_0000_0000, 64'hC004_0000_0000_0000,
                                64'h43D0_0000_0000_0000, 64'hC3E0_0000_0000_0000,
                                64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0001,
                                64'h3FE0_0000_0000_0000, 64'h8000_0000_0000_0000,
                                64'h43E0_0000_0000_0000, 64'h0000_0000_0000_0001,
                                64'h4330_0000_0000_0001};
      logic [63:0] vz  [11] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFE,
                                64'h4000_0000_0000_0000, IND, IND, IND,
                                64'h0, 64'h0, IND, 64'h0,
                                64'h0010_0000_0000_0001};
      logic vinv [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
      logic vinx [11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
      logic [63:0] z;
      int lat;
      logic inv, inx;
      bit ok;
      for (int i = 0; i < 11; i++) begin
         conv(vin[i], 1'b0, z, lat, inv, inx, ok);
         if (!ok) continue;
         n_cmp++;
         if (z !== vz[i]) begin
            n_err++;
            $display("FAIL directed_z[%0d]: in=%h got %h required %h", i, vin[i], z, vz[i]);
         end
         n_cmp++;
         if (lat !== 3) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d required 3", i, lat);
         end
`ifdef DOUBLE_TO_LONG_FLAGS_EN
         n_cmp++;
         if ({inv, inx} !== {vinv[i], vinx[i]}) begin
            n_err++;
            $display("FAIL directed_flags[%0d]: inv/inx got %b%b required %b%b",
                     i, inv, inx, vinv[i], vinx[i]);
         end
`else
         if (inv || inx || vinv[i] || vinx[i]) ; // flags not built
`endif
      end
   endtask

   task automatic test_random(input int count, input logic ack_idle, input string tag);
      logic [63:0] a, bits, z, ez;
      logic [10:0] e;
      int pick, lat;
      logic inv, inx, einv, einx;
      bit ok;
      output_z_ack = ack_idle;
      for (int i = 0; i < count; i++) begin
         pick = $urandom_range(0, 9);
         if (pick == 0)      e = 11'd0;
         else if (pick == 1) e = 11'h7FF;
         else                e = 11'($urandom_range(1010, 1090));
         bits = {$urandom, $urandom};
         a    = {1'($urandom_range(0, 1)), e, bits[51:0]};
         ref_conv(a, ez, einv, einx);
         conv(a, ack_idle, z, lat, inv, inx, ok);
         if (!ok) continue;
         n_cmp++;
         if (z !== ez || lat !== 3) begin
            n_err++;
            $display("FAIL %s_z[%0d]: in=%h got %h lat %0d required %h lat 3",
                     tag, i, a, z, lat, ez);
         end
`ifdef DOUBLE_TO_LONG_FLAGS_EN
         n_cmp++;
         if ({inv, inx} !== {einv, einx}) begin
            n_err++;
            $display("FAIL %s_flags[%0d]: in=%h inv/inx got %b%b required %b%b",
                     tag, i, a, inv, inx, einv, einx);
         end
`endif
      end
      output_z_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      int n;
      @(negedge clk);
      input_a = 64'h4024_0000_0000_0000; // 10.0
      input_a_stb = 1'b1;
      for (int i = 0; i < 20 && !input_a_ack; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      input_a_stb = 1'b0;
      n = 0;
      while (!output_z_stb && n < 20) begin @(negedge clk); n++; end
      held = output_z;
      n_cmp++;
      if (output_z_stb !== 1'b1 || held !== 64'd10) begin
         n_err++;
         $display("FAIL bp_result: stb=%b z=%h required 1 %h", output_z_stb, held, 64'd10);
      end
      // A new operand offered while busy must be ignored.
      input_a = 64'h4059_0000_0000_0000;
      input_a_stb = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (output_z !== held || input_a_ack !== 1'b0 || output_z_stb !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: z=%h ack=%b stb=%b required %h 0 1",
                     i, output_z, input_a_ack, output_z_stb, held);
         end
      end
      input_a_stb = 1'b0;
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      n_cmp++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: stb=%b ack=%b required 0 0", output_z_stb, input_a_ack);
      end
      @(negedge clk);
      n_cmp++;
      if (input_a_ack !== 1'b1 || output_z_stb !== 1'b0) begin
         n_err++;
         $display("FAIL bp_ack_return: ack=%b stb=%b required 1 0", input_a_ack, output_z_stb);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] z;
      int lat;
      logic inv, inx;
      bit ok;
      bit seen;
      conv(64'h3FF0_0000_0000_0000, 1'b0, z, lat, inv, inx, ok);
      n_cmp++;
      if (z !== 64'h1) begin
         n_err++;
         $display("FAIL pre_reset_z: got %h required 1", z);
      end
      @(negedge clk);
      input_a = 64'h4059_0000_0000_0000; // 100.0
      input_a_stb = 1'b1;
      for (int i = 0; i < 20 && !input_a_ack; i++) @(negedge clk);
      @(posedge clk);          // accept edge
      @(negedge clk);          // now in UNPACK
      input_a_stb = 1'b0;
      @(negedge clk);          // now in CONVERT
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({input_a_ack, output_z_stb, output_z} !== {1'b0, 1'b0, 64'h0}) begin
         n_err++;
         $display("FAIL mid_reset: ack=%b stb=%b z=%h required 0 0 0",
                  input_a_ack, output_z_stb, output_z);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (output_z_stb) seen = 1'b1;
      end
      n_cmp++;
      if (seen || input_a_ack !== 1'b1) begin
         n_err++;
         $display("FAIL after_reset_idle: stale_stb=%b ack=%b required 0 1", seen, input_a_ack);
      end
      conv(64'h3FF0_0000_0000_0000, 1'b0, z, lat, inv, inx, ok);
      n_cmp++;
      if (z !== 64'h1 || lat !== 3) begin
         n_err++;
         $display("FAIL post_reset_conv: z=%h lat=%0d required 1 3", z, lat);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random(40, 1'b0, "random");
      test_backpressure();
      test_reset_mid();
      test_random(12, 1'b1, "back_to_back");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
